jb_prach_nco_mixer: RTL and testbench
=====================================

Name: jb_prach_nco_mixer

Overview:
- PRACH frequency-shift mixer in the per-antenna TDM receive path.
- Sits directly downstream of the NCO/data latency-alignment delay line.
- Consumes the aligned complex sample stream and the matching NCO cos/sin stream, then forms a pipelined complex multiply (optionally conjugate) with rounding and saturation.
- Outputs the frequency-shifted stream tagged with an antenna index, toward the FFT.

Parameters:
- N_ANTENNAS, 4, antennas time-multiplexed on the stream, one sample per antenna in round-robin order.
- PRECISION, 16, bit width of each I/Q component, on both data and NCO.
- ANT_ID_BW, $clog2(N_ANTENNAS), width of tuser_out.

Ports:
- clk  input  1  processing clock.
- resetn  input  1  asynchronous active-low reset.
- clk_en  input  1  clock enable; all state advances only when high.
- tvalid_in  input  1  aligned data valid.
- tdata_in  input  2*PRECISION  aligned sample; [PRECISION-1:0]=I, [2*PRECISION-1:PRECISION]=Q; signed two's complement.
- nco_valid  input  1  NCO output valid.
- nco_data  input  2*PRECISION  [PRECISION-1:0]=cos, upper=sin; signed Q1.(PRECISION-1).
- conj_en  input  1  1 = multiply by conj(nco), 0 = multiply by nco.
- sat_clr  input  1  clears sat_flag.
- err_clr  input  1  clears align_err.
- tvalid_out  output  1  result valid.
- tdata_out  output  2*PRECISION  result, same packing as tdata_in.
- tuser_out  output  ANT_ID_BW  antenna index of the current output sample.
- sat_flag  output  1  sticky saturation indicator.
- align_err  output  1  sticky data/NCO valid mismatch indicator.

Behaviour:
- Reset: asynchronous on resetn low. All pipeline registers, tvalid_out, tdata_out, tuser_out, sat_flag, align_err and the antenna counter go to 0. Reset asserted mid-stream flushes the whole pipeline; in-flight samples are lost and never emitted.
- clk_en low: every register holds, including the counter and the sticky flags. Clear inputs are ignored.
- Latency: exactly 4 enabled cycles from input to output. Valid propagates with the data.
  - S1: register xi, xq, c, s, conj_en, and v = tvalid_in & nco_valid.
  - S2: four signed products xi*c, xq*s, xq*c, xi*s, each 2*PRECISION bits.
  - S3: 2*PRECISION+1-bit sums.
    - conj_en=0: I = xi*c - xq*s; Q = xq*c + xi*s.
    - conj_en=1: I = xi*c + xq*s; Q = xq*c - xi*s.
  - S4: round half-up by adding 2^(PRECISION-2), arithmetic shift right by PRECISION-1, then saturate to [-2^(PRECISION-1), 2^(PRECISION-1)-1].
- conj_en is captured per sample at S1. It may change between samples without corrupting samples already in flight.
- Data path registers load regardless of valid. Only valid gates the counter and flag updates.
- Saturation: sat_flag sets on any enabled cycle where a valid S4 sample clips in I or Q.
  - Stays set until sat_clr is high on an enabled cycle.
  - If a new clip coincides with sat_clr, set wins.
- Alignment check: align_err sets on any enabled cycle where tvalid_in != nco_valid.
  - A sample with only one of the two valids is dropped (v=0).
  - err_clr clears; simultaneous set wins.
- Antenna counter: tuser_out equals the counter value presented with each valid output.
  - Counter increments after each enabled cycle with tvalid_out=1.
  - Wraps from N_ANTENNAS-1 to 0.
  - Non-valid cycles do not advance it.
  - tuser_out holds its last value when tvalid_out=0.
- tdata_out holds its last registered value when tvalid_out=0. The value is not forced to 0.

Test Plan:
- Identity: nco cos=0x7FFF, sin=0, conj_en=0, data I=1000, Q=-2000 → 4 enabled cycles later I=1000, Q=-2000 (rounding), sat_flag=0.
- Quarter turn: cos=0, sin=0x7FFF, data I=1000, Q=0 → conj_en=0 gives I=0, Q=1000; conj_en=1 gives I=0, Q=-1000; toggle conj_en on back-to-back samples and confirm each output uses its own mode.
- Saturation: data I=Q=-32768, cos=sin=-32768, conj_en=0 → I=0, Q=32767, sat_flag=1; stays 1 over 10 further clean samples; sat_clr pulse → 0; sat_clr coincident with a new clip → remains 1.
- Counter wrap: 9 consecutive valid samples, N_ANTENNAS=4 → tuser_out 0,1,2,3,0,1,2,3,0; insert 3 idle cycles mid-burst → sequence unchanged.
- Misalignment: tvalid_in=1 with nco_valid=0 for one cycle → no output for that sample, align_err=1, tuser sequence not advanced; err_clr clears it.
- Gating/reset: hold clk_en low 5 cycles mid-burst → outputs and flags frozen, resume with latency counted in enabled cycles only; assert resetn low asynchronously mid-burst → all outputs 0 immediately, no stale samples after release.

Source files
------------

// File: rtl/jb_prach_nco_mixer.sv
// PRACH frequency-shift mixer: four-stage pipelined complex multiply of the aligned
// sample stream by the NCO (optionally conjugated), with round half-up and saturation.
module jb_prach_nco_mixer #(
    parameter int N_ANTENNAS = 4,
    parameter int PRECISION  = 16,
    parameter int ANT_ID_BW  = $clog2(N_ANTENNAS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clk_en,
    input  logic                   tvalid_in,
    input  logic [2*PRECISION-1:0] tdata_in,
    input  logic                   nco_valid,
    input  logic [2*PRECISION-1:0] nco_data,
    input  logic                   conj_en,
    input  logic                   sat_clr,
    input  logic                   err_clr,
    output logic                   tvalid_out,
    output logic [2*PRECISION-1:0] tdata_out,
    output logic [ANT_ID_BW-1:0]   tuser_out,
    output logic                   sat_flag,
    output logic                   align_err
);

    localparam int PW = 2 * PRECISION;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND =
        {{(SW-PRECISION+1){1'b0}}, 1'b1, {(PRECISION-2){1'b0}}};
    localparam logic [PRECISION-1:0] MAX_VAL = {1'b0, {(PRECISION-1){1'b1}}};
    localparam logic [PRECISION-1:0] MIN_VAL = {1'b1, {(PRECISION-1){1'b0}}};
    localparam logic [ANT_ID_BW-1:0] LAST_ANT = ANT_ID_BW'(N_ANTENNAS - 1);

    logic signed [PRECISION-1:0] xi_q, xq_q, c_q, s_q;
    logic                        conj1_q, v1_q;
    logic signed [PW-1:0]        pXc_q, pQs_q, pQc_q, pIs_q;
    logic signed [PW-1:0]        pXc_d, pQs_d, pQc_d, pIs_d;
    logic                        conj2_q, v2_q;
    logic signed [SW-1:0]        sumI_q, sumQ_q, sumI_d, sumQ_d;
    logic                        v3_q;
    logic [PW-1:0]               dout_q, dout_d;
    logic                        vout_q;
    logic [ANT_ID_BW-1:0]        tuser_q, tuser_d, cnt_q, cnt_d;
    logic                        sat_q, sat_d, err_q, err_d;
    logic [PRECISION:0]          resI, resQ;
    logic                        clip;

    // Returns {clipped, value}: round half-up, drop PRECISION-1 fraction bits, clamp.
    function automatic logic [PRECISION:0] satRound(input logic signed [SW-1:0] sum);
        logic signed [SW-1:0] shifted;
        shifted = (sum + RND) >>> (PRECISION - 1);
        if (shifted[SW-1:PRECISION-1] == '0 || shifted[SW-1:PRECISION-1] == '1)
            return {1'b0, shifted[PRECISION-1:0]};
        else if (shifted[SW-1])
            return {1'b1, MIN_VAL};
        else
            return {1'b1, MAX_VAL};
    endfunction

    always_comb begin
        pXc_d = PW'(xi_q) * PW'(c_q);
        pQs_d = PW'(xq_q) * PW'(s_q);
        pQc_d = PW'(xq_q) * PW'(c_q);
        pIs_d = PW'(xi_q) * PW'(s_q);

        if (conj2_q) begin
            sumI_d = SW'(pXc_q) + SW'(pQs_q);
            sumQ_d = SW'(pQc_q) - SW'(pIs_q);
        end else begin
            sumI_d = SW'(pXc_q) - SW'(pQs_q);
            sumQ_d = SW'(pQc_q) + SW'(pIs_q);
        end

        resI   = satRound(sumI_q);
        resQ   = satRound(sumQ_q);
        clip   = v3_q & (resI[PRECISION] | resQ[PRECISION]);
        dout_d = v3_q ? {resQ[PRECISION-1:0], resI[PRECISION-1:0]} : dout_q;

        // Sticky flags: a new event in the same cycle as its clear keeps the flag set.
        sat_d = sat_q;
        if (sat_clr) sat_d = 1'b0;
        if (clip)    sat_d = 1'b1;
        err_d = err_q;
        if (err_clr)                err_d = 1'b0;
        if (tvalid_in != nco_valid) err_d = 1'b1;

        cnt_d   = cnt_q;
        tuser_d = tuser_q;
        if (v3_q) begin
            tuser_d = cnt_q;
            cnt_d   = (cnt_q == LAST_ANT) ? '0 : cnt_q + ANT_ID_BW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xi_q    <= '0;
            xq_q    <= '0;
            c_q     <= '0;
            s_q     <= '0;
            conj1_q <= 1'b0;
            v1_q    <= 1'b0;
            pXc_q   <= '0;
            pQs_q   <= '0;
            pQc_q   <= '0;
            pIs_q   <= '0;
            conj2_q <= 1'b0;
            v2_q    <= 1'b0;
            sumI_q  <= '0;
            sumQ_q  <= '0;
            v3_q    <= 1'b0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
            tuser_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (clk_en) begin
            xi_q    <= tdata_in[PRECISION-1:0];
            xq_q    <= tdata_in[PW-1:PRECISION];
            c_q     <= nco_data[PRECISION-1:0];
            s_q     <= nco_data[PW-1:PRECISION];
            conj1_q <= conj_en;
            v1_q    <= tvalid_in & nco_valid;
            pXc_q   <= pXc_d;
            pQs_q   <= pQs_d;
            pQc_q   <= pQc_d;
            pIs_q   <= pIs_d;
            conj2_q <= conj1_q;
            v2_q    <= v1_q;
            sumI_q  <= sumI_d;
            sumQ_q  <= sumQ_d;
            v3_q    <= v2_q;
            dout_q  <= dout_d;
            vout_q  <= v3_q;
            tuser_q <= tuser_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign tvalid_out = vout_q;
    assign tdata_out  = dout_q;
    assign tuser_out  = tuser_q;
    assign sat_flag   = sat_q;
    assign align_err  = err_q;

endmodule

// File: tb/tb_jb_prach_nco_mixer.sv
// Directed bench for jb_prach_nco_mixer: hand-computed vectors pushed through the
// 4-cycle pipeline, with flag, gating, reset and antenna-counter checks.
module tb_jb_prach_nco_mixer;

    logic        clk = 1'b0;
    logic        resetn, clk_en, tvalid_in, nco_valid, conj_en, sat_clr, err_clr;
    logic [31:0] tdata_in, nco_data, tdata_out;
    logic        tvalid_out, sat_flag, align_err;
    logic [1:0]  tuser_out;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] lastData;
    logic [1:0]  lastTuser, expTuser;

    typedef struct packed {
        logic        tv;
        logic        nv;
        logic [15:0] xi, xq, c, s;
        logic        conj, sc, ec;
        logic [15:0] eI, eQ;
    } vec_t;

    vec_t stim[$];
    vec_t v;

    jb_prach_nco_mixer dut (
        .clk(clk), .resetn(resetn), .clk_en(clk_en),
        .tvalid_in(tvalid_in), .tdata_in(tdata_in),
        .nco_valid(nco_valid), .nco_data(nco_data),
        .conj_en(conj_en), .sat_clr(sat_clr), .err_clr(err_clr),
        .tvalid_out(tvalid_out), .tdata_out(tdata_out), .tuser_out(tuser_out),
        .sat_flag(sat_flag), .align_err(align_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic tv, input logic nv, input int xi, input int xq,
                                   input int c, input int s, input logic conj,
                                   input int eI, input int eQ);
        vec_t r;
        r.tv = tv;  r.nv = nv;
        r.xi = 16'(xi); r.xq = 16'(xq); r.c = 16'(c); r.s = 16'(s);
        r.conj = conj; r.sc = 1'b0; r.ec = 1'b0;
        r.eI = 16'(eI); r.eQ = 16'(eQ);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        checks++;
        if (obs !== expVal) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expVal);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveVec(input vec_t d);
        tvalid_in = d.tv;
        nco_valid = d.nv;
        tdata_in  = {d.xq, d.xi};
        nco_data  = {d.s, d.c};
        conj_en   = d.conj;
        sat_clr   = d.sc;
        err_clr   = d.ec;
    endtask

    task automatic driveIdle();
        driveVec(mkVec(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0));
    endtask

    task automatic expectSample(input string tag, input logic [15:0] eI, input logic [15:0] eQ);
        checkOutput({tag, " valid"}, 32'(tvalid_out), 32'(1));
        checkOutput({tag, " I"}, 32'(tdata_out[15:0]), 32'(eI));
        checkOutput({tag, " Q"}, 32'(tdata_out[31:16]), 32'(eQ));
        checkOutput({tag, " tuser"}, 32'(tuser_out), 32'(expTuser));
        lastData  = {eQ, eI};
        lastTuser = expTuser;
        expTuser  = (expTuser == 2'd3) ? 2'd0 : expTuser + 2'd1;
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, " valid"}, 32'(tvalid_out), 32'(0));
        checkOutput({tag, " hold data"}, tdata_out, lastData);
        checkOutput({tag, " hold tuser"}, 32'(tuser_out), 32'(lastTuser));
    endtask

    // Each stim entry is presented for one enabled cycle; its result is due 4 edges later.
    task automatic applyStimulus(input string name);
        int   n;
        logic ev;
        n = stim.size();
        for (int k = 0; k < n + 3; k++) begin
            if (k < n) driveVec(stim[k]);
            else       driveIdle();
            tick();
            ev = 1'b0;
            if (k >= 3) ev = stim[k-3].tv & stim[k-3].nv;
            if (ev) expectSample($sformatf("%s[%0d]", name, k - 3), stim[k-3].eI, stim[k-3].eQ);
            else    expectIdle($sformatf("%s@%0d", name, k));
        end
        driveIdle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetn = 1'b0;
        clk_en = 1'b1;
        driveIdle();
        lastData = '0; lastTuser = '0; expTuser = '0;
        #12;
        checkOutput("reset tvalid", 32'(tvalid_out), 32'(0));
        checkOutput("reset tdata", tdata_out, 32'(0));
        checkOutput("reset tuser", 32'(tuser_out), 32'(0));
        checkOutput("reset sat", 32'(sat_flag), 32'(0));
        checkOutput("reset align", 32'(align_err), 32'(0));
        tick();
        resetn = 1'b1;
        tick();

        // Identity, then quarter turns with conj_en toggling on back-to-back samples
        stim = {};
        stim.push_back(mkVec(1, 1, 1000, -2000, 32767, 0, 1'b0, 1000, -2000));
        stim.push_back(mkVec(1, 1, 1000, 0, 0, 32767, 1'b0, 0, 1000));
        stim.push_back(mkVec(1, 1, 1000, 0, 0, 32767, 1'b1, 0, -1000));
        stim.push_back(mkVec(1, 1, 1000, 0, 0, 32767, 1'b0, 0, 1000));
        stim.push_back(mkVec(1, 1, 1000, 0, 0, 32767, 1'b1, 0, -1000));
        applyStimulus("mix");
        checkOutput("mix sat", 32'(sat_flag), 32'(0));
        checkOutput("mix align", 32'(align_err), 32'(0));

        // Data valid without NCO valid: sample dropped, counter not advanced
        stim = {};
        stim.push_back(mkVec(1, 1, 1000, 0, 0, 32767, 1'b0, 0, 1000));
        stim.push_back(mkVec(1, 0, 5000, 5000, 32767, 0, 1'b0, 0, 0));
        stim.push_back(mkVec(1, 1, 1000, 0, 0, 32767, 1'b1, 0, -1000));
        applyStimulus("misalign");
        checkOutput("misalign align set", 32'(align_err), 32'(1));
        stim = {};
        v = mkVec(0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
        v.ec = 1'b1;
        stim.push_back(v);
        applyStimulus("errclr");
        checkOutput("err_clr clears", 32'(align_err), 32'(0));

        // Saturation: (-1-1j)*(-1-1j) in full scale gives I=0, Q=+2 which clips
        stim = {};
        stim.push_back(mkVec(1, 1, -32768, -32768, -32768, -32768, 1'b0, 0, 32767));
        applyStimulus("sat");
        checkOutput("sat set", 32'(sat_flag), 32'(1));
        stim = {};
        for (int i = 1; i <= 10; i++)
            stim.push_back(mkVec(1, 1, i * 100, -i * 150, 32767, 0, 1'b0, i * 100, -i * 150));
        applyStimulus("clean");
        checkOutput("sat sticky", 32'(sat_flag), 32'(1));
        stim = {};
        v = mkVec(0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
        v.sc = 1'b1;
        stim.push_back(v);
        applyStimulus("satclr");
        checkOutput("sat_clr clears", 32'(sat_flag), 32'(0));
        stim = {};
        stim.push_back(mkVec(1, 1, -32768, -32768, -32768, -32768, 1'b0, 0, 32767));
        stim.push_back(mkVec(0, 0, 0, 0, 0, 0, 1'b0, 0, 0));
        stim.push_back(mkVec(0, 0, 0, 0, 0, 0, 1'b0, 0, 0));
        v = mkVec(0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
        v.sc = 1'b1;
        stim.push_back(v);
        applyStimulus("satwin");
        checkOutput("sat set beats clear", 32'(sat_flag), 32'(1));

        // NCO valid without data valid also flags misalignment
        stim = {};
        stim.push_back(mkVec(0, 1, 0, 0, 32767, 0, 1'b0, 0, 0));
        applyStimulus("ncoonly");
        checkOutput("nco-only align set", 32'(align_err), 32'(1));

        // clk_en low for 5 cycles with a sample in S2; clears and inputs must be ignored
        driveVec(mkVec(1, 1, 300, -400, 32767, 0, 1'b0, 0, 0));
        tick();
        driveIdle();
        tick();
        clk_en = 1'b0;
        v = mkVec(1, 0, 7, 7, 7, 7, 1'b1, 0, 0);
        v.sc = 1'b1;
        v.ec = 1'b1;
        driveVec(v);
        for (int i = 0; i < 5; i++) begin
            tick();
            expectIdle($sformatf("gate%0d", i));
            checkOutput($sformatf("gate%0d sat", i), 32'(sat_flag), 32'(1));
            checkOutput($sformatf("gate%0d align", i), 32'(align_err), 32'(1));
        end
        clk_en = 1'b1;
        driveIdle();
        tick();
        expectIdle("resume e3");
        tick();
        expectSample("resume e4", 16'(300), 16'(-400));

        // Asynchronous reset with samples in flight
        driveVec(mkVec(1, 1, 111, 0, 32767, 0, 1'b0, 0, 0));
        tick();
        driveVec(mkVec(1, 1, 222, 0, 32767, 0, 1'b0, 0, 0));
        tick();
        driveVec(mkVec(1, 1, 333, 0, 32767, 0, 1'b0, 0, 0));
        tick();
        resetn = 1'b0;
        #1;
        checkOutput("async rst tvalid", 32'(tvalid_out), 32'(0));
        checkOutput("async rst tdata", tdata_out, 32'(0));
        checkOutput("async rst tuser", 32'(tuser_out), 32'(0));
        checkOutput("async rst sat", 32'(sat_flag), 32'(0));
        checkOutput("async rst align", 32'(align_err), 32'(0));
        driveIdle();
        tick();
        tick();
        resetn = 1'b1;
        lastData = '0; lastTuser = '0; expTuser = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expectIdle($sformatf("post-rst%0d", i));
        end

        // Nine samples with three idle cycles after the fifth: tuser 0,1,2,3,0,1,2,3,0
        stim = {};
        for (int i = 0; i < 9; i++) begin
            stim.push_back(mkVec(1, 1, i * 10 + 1, -i * 20, 32767, 0, 1'b0, i * 10 + 1, -i * 20));
            if (i == 4)
                for (int j = 0; j < 3; j++)
                    stim.push_back(mkVec(0, 0, 0, 0, 0, 0, 1'b0, 0, 0));
        end
        applyStimulus("wrap");
        checkOutput("wrap final tuser", 32'(tuser_out), 32'(0));
        checkOutput("wrap sat", 32'(sat_flag), 32'(0));
        checkOutput("wrap align", 32'(align_err), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
